// File: rtl/serial_operand_loader.sv
// serial_operand_loader
// ---------------------
// Parallel-to-serial front end for the bit-serial adder. A WIDTH-bit operand
// pair and a carry-in are accepted through a valid/ready handshake. They are
// then presented LSB-first, one bit per clock, on ser_a/ser_b/ser_cin. While no
// word is being shifted, ser_rst holds the adder in reset so that its carry
// state is cleared between words.
//
// Optional feature: define SERIAL_LOADER_SUB_EN to enable subtraction. When
// in_sub is accepted high, ser_b carries ~in_b and the bit-0 carry-in is forced
// to 1, so the downstream adder computes A-B. Without the macro, in_sub is
// ignored.
//
// Parameters:
//   WIDTH      operand width in bits (2..32)
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      asynchronous active-high reset
//   in_valid   operand word offered by the source
//   in_ready   loader can accept a word this cycle
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry-in for the word
//   in_sub     subtract request (SERIAL_LOADER_SUB_EN builds only)
//   ser_a      serial A bit to the adder
//   ser_b      serial B bit to the adder
//   ser_cin    carry-in bit to the adder, nonzero only on bit 0
//   ser_rst    adder reset, high whenever no word is being shifted
//   ser_valid  ser_a/ser_b carry a live bit
//   ser_first  current bit is bit 0
//   ser_last   current bit is bit WIDTH-1
//   busy       word in flight (same as ser_valid)
module serial_operand_loader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
  output logic             ser_rst,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  // One extra counter bit so the counter can hold WIDTH itself, which marks
  // the edge that ends the word, without ever wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic             ready_q, ready_d;
  logic             ser_a_q, ser_a_d;
  logic             ser_b_q, ser_b_d;
  logic             ser_cin_q, ser_cin_d;
  logic             ser_rst_q, ser_rst_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;
  logic             ser_last_q, ser_last_d;

  // Operand B and carry-in as they will be shifted out. With subtraction
  // enabled, the in_sub decision is folded into the latched B bits and the
  // bit-0 carry at accept time. That is the only place in_sub matters, so no
  // separate flag register is needed.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef SERIAL_LOADER_SUB_EN
  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
  logic unused_sub;
  assign unused_sub = in_sub;
  assign b_eff      = in_b;
  assign cin_eff    = in_cin;
`endif

  // State and output registers. Reset abandons any word in flight at once:
  // all serial outputs drop and the adder is held in reset. in_ready stays low
  // until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sha_q       <= '0;
      shb_q       <= '0;
      ready_q     <= 1'b0;
      ser_a_q     <= 1'b0;
      ser_b_q     <= 1'b0;
      ser_cin_q   <= 1'b0;
      ser_rst_q   <= 1'b1;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sha_q       <= sha_d;
      shb_q       <= shb_d;
      ready_q     <= ready_d;
      ser_a_q     <= ser_a_d;
      ser_b_q     <= ser_b_d;
      ser_cin_q   <= ser_cin_d;
      ser_rst_q   <= ser_rst_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
    end
  end

  // Next-state logic. Bit 0 is registered at the accept edge. The remaining
  // bits are taken from the LSB of the shift registers, which already hold the
  // operands pre-shifted by one. The counter holds the index of the bit being
  // registered. When it reaches WIDTH, the word has been fully emitted and the
  // edge returns the block to IDLE, giving at least one idle cycle with the
  // adder in reset before the next word.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sha_d       = sha_q;
    shb_d       = shb_q;
    ready_d     = ready_q;
    ser_a_d     = ser_a_q;
    ser_b_d     = ser_b_q;
    ser_cin_d   = ser_cin_q;
    ser_rst_d   = ser_rst_q;
    ser_valid_d = ser_valid_q;
    ser_first_d = ser_first_q;
    ser_last_d  = ser_last_q;

    unique case (state_q)
      IDLE: begin
        ser_a_d     = 1'b0;
        ser_b_d     = 1'b0;
        ser_cin_d   = 1'b0;
        ser_rst_d   = 1'b1;
        ser_valid_d = 1'b0;
        ser_first_d = 1'b0;
        ser_last_d  = 1'b0;
        ready_d     = 1'b1;
        if (in_valid && ready_q) begin
          state_d     = SHIFT;
          cnt_d       = CNT_ONE;
          sha_d       = in_a >> 1;
          shb_d       = b_eff >> 1;
          ser_a_d     = in_a[0];
          ser_b_d     = b_eff[0];
          ser_cin_d   = cin_eff;
          ser_rst_d   = 1'b0;
          ser_valid_d = 1'b1;
          ser_first_d = 1'b1;
          ready_d     = 1'b0;
        end
      end

      SHIFT: begin
        ready_d = 1'b0;
        if (cnt_q == CNT_END) begin
          state_d     = IDLE;
          cnt_d       = '0;
          sha_d       = '0;
          shb_d       = '0;
          ser_a_d     = 1'b0;
          ser_b_d     = 1'b0;
          ser_cin_d   = 1'b0;
          ser_rst_d   = 1'b1;
          ser_valid_d = 1'b0;
          ser_first_d = 1'b0;
          ser_last_d  = 1'b0;
          ready_d     = 1'b1;
        end else begin
          cnt_d       = cnt_q + CNT_ONE;
          sha_d       = sha_q >> 1;
          shb_d       = shb_q >> 1;
          ser_a_d     = sha_q[0];
          ser_b_d     = shb_q[0];
          ser_cin_d   = 1'b0;
          ser_first_d = 1'b0;
          ser_last_d  = (cnt_q == CNT_LAST);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = ready_q;
  assign ser_a     = ser_a_q;
  assign ser_b     = ser_b_q;
  assign ser_cin   = ser_cin_q;
  assign ser_rst   = ser_rst_q;
  assign ser_valid = ser_valid_q;
  assign ser_first = ser_first_q;
  assign ser_last  = ser_last_q;
  assign busy      = ser_valid_q;

endmodule

// File: tb/tb_serial_operand_loader.sv
// tb_serial_operand_loader
// ------------------------
// Scoreboard bench for serial_operand_loader. Two instances share the clock
// and reset: a WIDTH=4 instance and a WIDTH=8 instance. For each accepted word,
// the stimulus tasks push the hand-computed per-bit expectations into a queue.
// A monitor per instance pops one entry for every cycle its ser_valid is high.
// On idle cycles, the monitor checks that the outputs are quiet.
module tb_serial_operand_loader;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
    logic first;
    logic last;
  } bit_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       in_valid = 1'b0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_cin = 1'b0;
  logic       in_sub = 1'b0;
  logic       in_ready, ser_a, ser_b, ser_cin, ser_rst;
  logic       ser_valid, ser_first, ser_last, busy;

  logic       in_valid8 = 1'b0;
  logic [7:0] in_a8 = '0;
  logic [7:0] in_b8 = '0;
  logic       in_cin8 = 1'b0;
  logic       in_sub8 = 1'b0;
  logic       in_ready8, ser_a8, ser_b8, ser_cin8, ser_rst8;
  logic       ser_valid8, ser_first8, ser_last8, busy8;

  int   checks = 0;
  int   failures = 0;
  bit_t q4[$];
  bit_t q8[$];
  logic prev4 = 1'b0;
  logic prev8 = 1'b0;
  int   run4 = 0;
  int   run8 = 0;

  serial_operand_loader #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .ser_a(ser_a), .ser_b(ser_b), .ser_cin(ser_cin), .ser_rst(ser_rst),
    .ser_valid(ser_valid), .ser_first(ser_first), .ser_last(ser_last),
    .busy(busy)
  );

  serial_operand_loader #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_cin(in_cin8), .in_sub(in_sub8),
    .ser_a(ser_a8), .ser_b(ser_b8), .ser_cin(ser_cin8), .ser_rst(ser_rst8),
    .ser_valid(ser_valid8), .ser_first(ser_first8), .ser_last(ser_last8),
    .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer a word to the 4-bit instance and wait until it is accepted.
  // in_valid is left high, so the caller decides whether the next word follows
  // immediately or the source goes quiet.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic cin, input logic sub,
                               input logic [3:0] expA, input logic [3:0] expB,
                               input logic expCin);
    int waited;
    bit_t e;
    waited = 0;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    in_valid = 1'b1;
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("w4_accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      e.a = expA[k];
      e.b = expB[k];
      e.cin = (k == 0) ? expCin : 1'b0;
      e.first = (k == 0);
      e.last = (k == 3);
      q4.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b,
                                input logic cin,
                                input logic [7:0] expA, input logic [7:0] expB,
                                input logic expCin);
    int waited;
    bit_t e;
    waited = 0;
    @(negedge clk);
    in_a8 = a;
    in_b8 = b;
    in_cin8 = cin;
    in_valid8 = 1'b1;
    while (!in_ready8 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready8) begin
      checkOutput("w8_accept_timeout", 0, 1);
      in_valid8 = 1'b0;
      return;
    end
    for (int k = 0; k < 8; k++) begin
      e.a = expA[k];
      e.b = expB[k];
      e.cin = (k == 0) ? expCin : 1'b0;
      e.first = (k == 0);
      e.last = (k == 7);
      q8.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  // Monitor for the 4-bit instance.
  always @(negedge clk) begin
    bit_t e;
    if (reset) begin
      prev4 = 1'b0;
      run4 = 0;
    end else begin
      if (ser_valid) begin
        if (q4.size() == 0) begin
          checkOutput("w4_unexpected_bit", 1, 0);
        end else begin
          e = q4.pop_front();
          checkOutput("w4_bits", {27'd0, ser_a, ser_b, ser_cin, ser_first, ser_last}, {27'd0, e});
        end
        checkOutput("w4_busy_rst_ready", {29'd0, busy, ser_rst, in_ready}, 3'b100);
        if (ser_first) checkOutput("w4_gap_before_word", {31'd0, prev4}, 0);
        run4++;
      end else begin
        if (prev4) checkOutput("w4_valid_length", run4, 4);
        run4 = 0;
        checkOutput("w4_idle_outputs", {26'd0, ser_a, ser_b, ser_cin, ser_first, ser_last, busy}, 0);
        checkOutput("w4_idle_rst", {31'd0, ser_rst}, 1);
      end
      prev4 = ser_valid;
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    bit_t e;
    if (reset) begin
      prev8 = 1'b0;
      run8 = 0;
    end else begin
      if (ser_valid8) begin
        if (q8.size() == 0) begin
          checkOutput("w8_unexpected_bit", 1, 0);
        end else begin
          e = q8.pop_front();
          checkOutput("w8_bits", {27'd0, ser_a8, ser_b8, ser_cin8, ser_first8, ser_last8}, {27'd0, e});
        end
        checkOutput("w8_busy_rst_ready", {29'd0, busy8, ser_rst8, in_ready8}, 3'b100);
        run8++;
      end else begin
        if (prev8) checkOutput("w8_valid_length", run8, 8);
        run8 = 0;
        checkOutput("w8_idle_outputs", {26'd0, ser_a8, ser_b8, ser_cin8, ser_first8, ser_last8, busy8}, 0);
        checkOutput("w8_idle_rst", {31'd0, ser_rst8}, 1);
      end
      prev8 = ser_valid8;
    end
  end

  initial begin
    int waited;

    // Reset for 20ns: outputs quiet, adder held in reset, not ready.
    reset = 1'b1;
    #15;
    checkOutput("reset_outputs", {24'd0, ser_a, ser_b, ser_cin, ser_valid, ser_first, ser_last, busy, in_ready}, 0);
    checkOutput("reset_ser_rst", {31'd0, ser_rst}, 1);
    #5;
    reset = 1'b0;
    #2;
    checkOutput("ready_low_before_edge", {31'd0, in_ready}, 0);
    @(negedge clk);
    checkOutput("ready_after_release", {31'd0, in_ready}, 1);

    // Single word, with a pulse on in_valid.
    applyStimulus(4'hF, 4'hB, 1'b1, 1'b0, 4'b1111, 4'b1011, 1'b1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Two words back to back, with in_valid held high throughout.
    applyStimulus(4'h3, 4'h5, 1'b0, 1'b0, 4'b0011, 4'b0101, 1'b0);
    applyStimulus(4'hA, 4'h6, 1'b0, 1'b0, 4'b1010, 4'b0110, 1'b0);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Word offered while another is in flight: it must wait for IDLE.
    applyStimulus(4'h6, 4'hC, 1'b0, 1'b0, 4'b0110, 4'b1100, 1'b0);
    applyStimulus(4'h9, 4'h0, 1'b0, 1'b0, 4'b1001, 4'b0000, 1'b0);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset asserted between edges while bit 2 is on the outputs.
    applyStimulus(4'h7, 4'h2, 1'b1, 1'b0, 4'b0111, 4'b0010, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midword_reset_outputs", {24'd0, ser_a, ser_b, ser_cin, ser_valid, ser_first, ser_last, busy, in_ready}, 0);
    checkOutput("midword_reset_ser_rst", {31'd0, ser_rst}, 1);
    q4.delete();
    q8.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(4'h5, 4'hA, 1'b0, 1'b0, 4'b0101, 4'b1010, 1'b0);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Subtract request: ~B with a forced carry only when the feature is built.
`ifdef SERIAL_LOADER_SUB_EN
    applyStimulus(4'h5, 4'h3, 1'b0, 1'b1, 4'b0101, 4'b1100, 1'b1);
`else
    applyStimulus(4'h5, 4'h3, 1'b0, 1'b1, 4'b0101, 4'b0011, 1'b0);
`endif
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    applyStimulus(4'h2, 4'h1, 1'b1, 1'b0, 4'b0010, 4'b0001, 1'b1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    // 8-bit instance: single-bit operands at both ends, then a mixed pattern.
    applyStimulus8(8'h80, 8'h01, 1'b0, 8'h80, 8'h01, 1'b0);
    repeat (10) @(negedge clk);
    applyStimulus8(8'hA5, 8'h3C, 1'b1, 8'hA5, 8'h3C, 1'b1);
    repeat (10) @(negedge clk);

    // Drain both scoreboards.
    waited = 0;
    while ((q4.size() != 0 || q8.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("scoreboard_drained", q4.size() + q8.size(), 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
